// File: rtl/ddr_axi_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_axi_cmd_arbiter
//
// Purpose:
//   Shares the DDR controller's single combined AXI address channel between
//   the video frame writer (write requester) and the HDMI scan-out reader
//   (read requester). One command is in flight on the address channel at a
//   time. Ties are broken round-robin, and the reader gets strict priority
//   while its FIFO is urgent. Per-direction outstanding bursts are capped by
//   snooping the B and R response channels.
//
// Ports:
//   aclk_i, arst_i          clock, synchronous active-high reset
//   wr_req_*                write command request (addr, len-1, valid) and
//                           a one-cycle ready/accept pulse
//   rd_req_*                read command request, same handshake
//   rd_urgent_i             scan-out FIFO below its low-water mark
//   m_axi_a*                combined AXI address channel (master side)
//   m_axi_b*/m_axi_r*       response snoop inputs (monitor only)
//   wr_/rd_outstanding_o    outstanding burst counters
//   err_o                   sticky counter protocol error
// ---------------------------------------------------------------------------
module ddr_axi_cmd_arbiter #(
    parameter int unsigned MAX_OUT = 4,
    parameter logic [7:0]  WR_ID   = 8'h01,
    parameter logic [7:0]  RD_ID   = 8'h02,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             aclk_i,
    input  logic             arst_i,
    input  logic [31:0]      wr_req_addr_i,
    input  logic [7:0]       wr_req_len_i,
    input  logic             wr_req_valid_i,
    output logic             wr_req_ready_o,
    input  logic [31:0]      rd_req_addr_i,
    input  logic [7:0]       rd_req_len_i,
    input  logic             rd_req_valid_i,
    output logic             rd_req_ready_o,
    input  logic             rd_urgent_i,
    output logic [7:0]       m_axi_aid_o,
    output logic [31:0]      m_axi_aaddr_o,
    output logic [7:0]       m_axi_alen_o,
    output logic [2:0]       m_axi_asize_o,
    output logic [1:0]       m_axi_aburst_o,
    output logic [1:0]       m_axi_alock_o,
    output logic             m_axi_atype_o,
    output logic             m_axi_avalid_o,
    input  logic             m_axi_aready_i,
    input  logic             m_axi_bvalid_i,
    input  logic             m_axi_bready_i,
    input  logic             m_axi_rvalid_i,
    input  logic             m_axi_rready_i,
    input  logic             m_axi_rlast_i,
    output logic [CNT_W-1:0] wr_outstanding_o,
    output logic [CNT_W-1:0] rd_outstanding_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              avalid_r;
    logic [7:0]        aid_r;
    logic [31:0]       aaddr_r;
    logic [7:0]        alen_r;
    logic              atype_r;
    logic              wr_ready_r;
    logic              rd_ready_r;
    logic              last_grant_wr_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic              err_r;

    logic              wr_elig_s;
    logic              rd_elig_s;
    logic              grant_wr_s;
    logic              grant_rd_s;
    logic              accept_s;
    logic [CNT_W:0]    wr_upd_s;
    logic [CNT_W:0]    rd_upd_s;

    // Counter update: returns {error, next_count}. Simultaneous increment and
    // decrement cancel out; a decrement at zero or an increment past the cap
    // leaves the count unchanged and flags an error.
    function automatic logic [CNT_W:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W:0] res;
        case ({inc, dec})
            2'b10: begin
                if (cnt >= MAX_OUT_C) begin
                    res = {1'b1, cnt};
                end else begin
                    res = {1'b0, cnt + ONE_C};
                end
            end
            2'b01: begin
                if (cnt == ZERO_C) begin
                    res = {1'b1, ZERO_C};
                end else begin
                    res = {1'b0, cnt - ONE_C};
                end
            end
            default: res = {1'b0, cnt};
        endcase
        return res;
    endfunction

    // Eligibility and counter next-values, always from registered counts so a
    // response in the grant cycle cannot influence that cycle's decision.
    always_comb begin
        wr_elig_s = wr_req_valid_i && (wr_cnt_r < MAX_OUT_C);
        rd_elig_s = rd_req_valid_i && (rd_cnt_r < MAX_OUT_C);
        accept_s  = avalid_r && m_axi_aready_i;
        wr_upd_s  = cnt_next(wr_cnt_r, accept_s && atype_r,
                             m_axi_bvalid_i && m_axi_bready_i);
        rd_upd_s  = cnt_next(rd_cnt_r, accept_s && !atype_r,
                             m_axi_rvalid_i && m_axi_rready_i && m_axi_rlast_i);
    end

    // Next-state and grant decision.
    always_comb begin
        state_nxt_s = state_r;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Urgency overrides fairness, but rd_elig_s already embeds the cap.
                if (rd_urgent_i && rd_elig_s) begin
                    grant_rd_s = 1'b1;
                end else if (wr_elig_s && rd_elig_s) begin
                    if (last_grant_wr_r) begin
                        grant_rd_s = 1'b1;
                    end else begin
                        grant_wr_s = 1'b1;
                    end
                end else if (wr_elig_s) begin
                    grant_wr_s = 1'b1;
                end else if (rd_elig_s) begin
                    grant_rd_s = 1'b1;
                end else begin
                    grant_wr_s = 1'b0;
                    grant_rd_s = 1'b0;
                end
                if (grant_wr_s) begin
                    state_nxt_s = ST_ISSUE_WR;
                end else if (grant_rd_s) begin
                    state_nxt_s = ST_ISSUE_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE_WR, ST_ISSUE_RD: begin
                if (m_axi_aready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, command registers, ready pulses, counters and sticky error.
    always_ff @(posedge aclk_i) begin
        if (arst_i) begin
            state_r         <= ST_IDLE;
            avalid_r        <= 1'b0;
            aid_r           <= 8'h00;
            aaddr_r         <= 32'h0000_0000;
            alen_r          <= 8'h00;
            atype_r         <= 1'b0;
            wr_ready_r      <= 1'b0;
            rd_ready_r      <= 1'b0;
            last_grant_wr_r <= 1'b1;
            wr_cnt_r        <= ZERO_C;
            rd_cnt_r        <= ZERO_C;
            err_r           <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wr_ready_r <= grant_wr_s;
            rd_ready_r <= grant_rd_s;
            if (grant_wr_s) begin
                avalid_r        <= 1'b1;
                aid_r           <= WR_ID;
                aaddr_r         <= {wr_req_addr_i[31:4], 4'h0};
                alen_r          <= wr_req_len_i;
                atype_r         <= 1'b1;
                last_grant_wr_r <= 1'b1;
            end else if (grant_rd_s) begin
                avalid_r        <= 1'b1;
                aid_r           <= RD_ID;
                aaddr_r         <= {rd_req_addr_i[31:4], 4'h0};
                alen_r          <= rd_req_len_i;
                atype_r         <= 1'b0;
                last_grant_wr_r <= 1'b0;
            end else if (accept_s) begin
                avalid_r <= 1'b0;
            end else begin
                avalid_r <= avalid_r;
            end
            wr_cnt_r <= wr_upd_s[CNT_W-1:0];
            rd_cnt_r <= rd_upd_s[CNT_W-1:0];
            err_r    <= err_r | wr_upd_s[CNT_W] | rd_upd_s[CNT_W];
        end
    end

    assign wr_req_ready_o   = wr_ready_r;
    assign rd_req_ready_o   = rd_ready_r;
    assign m_axi_aid_o      = aid_r;
    assign m_axi_aaddr_o    = aaddr_r;
    assign m_axi_alen_o     = alen_r;
    assign m_axi_asize_o    = 3'd4;
    assign m_axi_aburst_o   = 2'b01;
    assign m_axi_alock_o    = 2'b00;
    assign m_axi_atype_o    = atype_r;
    assign m_axi_avalid_o   = avalid_r;
    assign wr_outstanding_o = wr_cnt_r;
    assign rd_outstanding_o = rd_cnt_r;
    assign err_o            = err_r;

endmodule
